// File: rtl/rv32i_types.sv
// Shared RV32I core types. Holds the common-data-bus payload and the port map
// used by the CDB arbiter to identify which execution unit owns each request line.
package rv32i_types;

    localparam int XLEN       = 32;
    localparam int ROB_IDX_W  = 5;
    localparam int AREG_IDX_W = 5;
    localparam int PREG_IDX_W = 6;

    // One completed result as broadcast on the common data bus.
    typedef struct packed {
        logic [XLEN-1:0]       result;
        logic [ROB_IDX_W-1:0]  rob_index;
        logic [AREG_IDX_W-1:0] areg_index;
        logic [PREG_IDX_W-1:0] preg_index;
        logic                  cdb_valid;
    } cdb_t;

    // Number of execution units competing for the CDB.
    localparam int NUM_CDB_FU = 4;

    // Request-port index of each execution unit; index 0 has the highest fixed priority.
    typedef enum {FU_ALU, FU_MUL, FU_BR, FU_LSU} fu_idx_e;

endpackage

// File: rtl/rr_picker.sv
// Rotating find-first picker. The request vector is rotated so that the search
// starts at i_ptr, the lowest set bit of the rotated vector is found, and its
// position is mapped back to an absolute index. With i_ptr tied to zero this
// degenerates into a plain fixed-priority (lowest index wins) picker.
module rr_picker #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_gnt,
    output logic [$clog2(N)-1:0] o_gntIdx,
    output logic                 o_gntAny
);

    localparam int IdxW = $clog2(N);

    logic [2*N-1:0] w_doubled;
    logic [N-1:0]   w_rotated;
    logic [IdxW-1:0] w_offset;
    logic           w_found;
    logic [IdxW:0]  w_sum;

    // Concatenate the request vector with itself and shift right by the pointer so the
    // low N bits hold the requests in search order, starting at i_ptr and wrapping.
    always_comb begin
        w_doubled = {i_req, i_req} >> i_ptr;
        w_rotated = w_doubled[N-1:0];
    end

    // Find the first set bit of the rotated vector; scanning downwards lets the lowest hit win.
    always_comb begin
        w_found  = 1'b0;
        w_offset = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rotated[i]) begin
                w_found  = 1'b1;
                w_offset = IdxW'(i);
            end
        end
    end

    // Undo the rotation: absolute index = (offset + ptr) mod N, then build the one-hot grant.
    always_comb begin
        w_sum = {1'b0, w_offset} + {1'b0, i_ptr};
        if (w_sum >= (IdxW + 1)'(N)) begin
            w_sum = w_sum - (IdxW + 1)'(N);
        end
        o_gntIdx = w_sum[IdxW-1:0];
        o_gntAny = w_found;
        o_gnt    = w_found ? (N'(1) << o_gntIdx) : '0;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter. Picks at most one completed result per cycle from the
// execution units, hands the winner its ready, and registers the winning payload
// onto the single broadcast bus read by the ROB, wakeup logic and regfile write port.
// A branch flush squashes both the grant and the broadcast for that cycle.
module cdb_arbiter
    import rv32i_types::*;
#(
    parameter int NUM_FU   = NUM_CDB_FU,
    parameter int ARB_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 branch_flush,
    input  logic [NUM_FU-1:0]    fu_valid,
    input  cdb_t [NUM_FU-1:0]    fu_cdb,
    output logic [NUM_FU-1:0]    fu_ready,
    output cdb_t                 cdb_out,
    output logic                 cdb_out_valid
);

    localparam int PtrW = $clog2(NUM_FU);
    localparam logic [PtrW-1:0] LastIdx = PtrW'(NUM_FU - 1);

    logic [PtrW-1:0]   r_rrPtr;
    logic [PtrW-1:0]   w_searchPtr;
    logic [PtrW-1:0]   w_gntIdx;
    logic [PtrW-1:0]   w_nextPtr;
    logic [NUM_FU-1:0] w_req;
    logic [NUM_FU-1:0] w_gnt;
    logic              w_gntAny;
    cdb_t              w_payload;

    // Requests are masked while in reset or during a flush so no unit is told its result was taken.
    // Fixed-priority mode always searches from index 0.
    always_comb begin
        w_req       = fu_valid & {NUM_FU{~(branch_flush | rst)}};
        w_searchPtr = (ARB_MODE == 1) ? '0 : r_rrPtr;
    end

    rr_picker #(
        .N (NUM_FU)
    ) u_picker (
        .i_req    (w_req),
        .i_ptr    (w_searchPtr),
        .o_gnt    (w_gnt),
        .o_gntIdx (w_gntIdx),
        .o_gntAny (w_gntAny)
    );

    // The grant goes straight back to the units; the winning payload is selected and
    // its cdb_valid forced high so consumers can trust the field without the side valid.
    always_comb begin
        fu_ready            = w_gnt;
        w_payload           = fu_cdb[w_gntIdx];
        w_payload.cdb_valid = 1'b1;
    end

    // Round-robin pointer moves to just past the winner; it holds when nothing is granted
    // (including flush cycles) and never moves in fixed-priority mode.
    always_comb begin
        w_nextPtr = r_rrPtr;
        if ((ARB_MODE == 0) && w_gntAny) begin
            w_nextPtr = (w_gntIdx == LastIdx) ? '0 : w_gntIdx + PtrW'(1);
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rrPtr <= '0;
        end else begin
            r_rrPtr <= w_nextPtr;
        end
    end

    // Broadcast register: one cycle of valid per grant, cleared to zero on idle or flushed cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_out       <= '0;
            cdb_out_valid <= 1'b0;
        end else if (w_gntAny) begin
            cdb_out       <= w_payload;
            cdb_out_valid <= 1'b1;
        end else begin
            cdb_out       <= '0;
            cdb_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter. One instance runs round-robin, a second runs
// fixed priority; both share clock, reset, flush and the payload table.
module tb_cdb_arbiter;
    import rv32i_types::*;

    logic       clk;
    logic       rst;
    logic       branchFlush;
    logic [3:0] fuValid;
    logic [3:0] fixValid;
    cdb_t [3:0] fuCdb;
    logic [3:0] fuReady;
    logic [3:0] fixReady;
    cdb_t       cdbOut;
    cdb_t       fixCdbOut;
    logic       cdbOutValid;
    logic       fixCdbOutValid;

    int cmpCount;
    int errCount;

    cdb_arbiter #(
        .NUM_FU   (4),
        .ARB_MODE (0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .branch_flush  (branchFlush),
        .fu_valid      (fuValid),
        .fu_cdb        (fuCdb),
        .fu_ready      (fuReady),
        .cdb_out       (cdbOut),
        .cdb_out_valid (cdbOutValid)
    );

    cdb_arbiter #(
        .NUM_FU   (4),
        .ARB_MODE (1)
    ) dutFix (
        .clk           (clk),
        .rst           (rst),
        .branch_flush  (branchFlush),
        .fu_valid      (fixValid),
        .fu_cdb        (fuCdb),
        .fu_ready      (fixReady),
        .cdb_out       (fixCdbOut),
        .cdb_out_valid (fixCdbOutValid)
    );

    // Free-running clock, posedges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if the observed value differs from the expectation.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        cmpCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive inputs on the falling edge and let the combinational grant settle.
    task automatic applyStimulus(input logic [3:0] v, input logic f, input logic [3:0] fv);
        @(negedge clk);
        fuValid     = v;
        branchFlush = f;
        fixValid    = fv;
        #1;
    endtask

    // Advance past the next rising edge so registered outputs can be sampled.
    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    // Expected broadcast for a unit: its table payload with cdb_valid forced high.
    function automatic cdb_t expCdb(input logic [1:0] unit);
        cdb_t c;
        c           = fuCdb[unit];
        c.cdb_valid = 1'b1;
        return c;
    endfunction

    cdb_t       expPayload;
    logic [3:0] expReady;

    initial begin
        cmpCount    = 0;
        errCount    = 0;
        rst         = 1'b1;
        branchFlush = 1'b0;
        fuValid     = 4'b1111;
        fixValid    = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            fuCdb[i].result     = 32'hA0A0_0000 | 32'(i);
            fuCdb[i].rob_index  = 5'(i + 1);
            fuCdb[i].areg_index = 5'(i + 10);
            fuCdb[i].preg_index = 6'(i + 20);
            fuCdb[i].cdb_valid  = 1'b0;
        end

        // Reset: ready masked while reset is held even with every unit requesting.
        #1;
        checkOutput("rst_ready_held", 64'(fuReady), 64'(4'b0000));
        checkOutput("rst_valid_held", 64'(cdbOutValid), 64'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_first_ready", 64'(fuReady), 64'(4'b0001));
        stepEdge();
        checkOutput("rst_pre_valid", 64'(cdbOutValid), 64'(1'b1));
        checkOutput("rst_pre_payload", 64'(cdbOut), 64'(expCdb(2'd0)));
        // Mid-cycle reset drops the broadcast without waiting for a clock edge.
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst_async_valid", 64'(cdbOutValid), 64'(1'b0));
        checkOutput("rst_async_payload", 64'(cdbOut), 64'(0));
        checkOutput("rst_async_ready", 64'(fuReady), 64'(4'b0000));
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_ptr_zero", 64'(fuReady), 64'(4'b0001));
        fuValid = 4'b0000;
        stepEdge();
        checkOutput("idle_valid", 64'(cdbOutValid), 64'(1'b0));

        // Single request from unit 1.
        fuCdb[1].result     = 32'hDEAD_BEEF;
        fuCdb[1].rob_index  = 5'd5;
        fuCdb[1].areg_index = 5'd3;
        fuCdb[1].preg_index = 6'd12;
        fuCdb[1].cdb_valid  = 1'b0;
        expPayload.result     = 32'hDEAD_BEEF;
        expPayload.rob_index  = 5'd5;
        expPayload.areg_index = 5'd3;
        expPayload.preg_index = 6'd12;
        expPayload.cdb_valid  = 1'b1;
        applyStimulus(4'b0010, 1'b0, 4'b0000);
        checkOutput("single_ready", 64'(fuReady), 64'(4'b0010));
        stepEdge();
        checkOutput("single_valid", 64'(cdbOutValid), 64'(1'b1));
        checkOutput("single_payload", 64'(cdbOut), 64'(expPayload));
        applyStimulus(4'b0000, 1'b0, 4'b0000);
        checkOutput("single_ready_off", 64'(fuReady), 64'(4'b0000));
        stepEdge();
        checkOutput("single_valid_off", 64'(cdbOutValid), 64'(1'b0));
        checkOutput("single_payload_off", 64'(cdbOut), 64'(0));

        // Round-robin from a freshly reset pointer: grant order 0,1,2,3,0 on consecutive cycles.
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'b1111, 1'b0, 4'b0000);
            expReady = 4'(1 << (k % 4));
            checkOutput($sformatf("rr_ready_%0d", k), 64'(fuReady), 64'(expReady));
            stepEdge();
            checkOutput($sformatf("rr_valid_%0d", k), 64'(cdbOutValid), 64'(1'b1));
            checkOutput($sformatf("rr_payload_%0d", k), 64'(cdbOut), 64'(expCdb(2'(k % 4))));
        end

        // Wrap and skip: pointer is 1; grant unit 2 to move it to 3, then search wraps to unit 0.
        applyStimulus(4'b0100, 1'b0, 4'b0000);
        checkOutput("wrap_setup_ready", 64'(fuReady), 64'(4'b0100));
        stepEdge();
        applyStimulus(4'b0011, 1'b0, 4'b0000);
        checkOutput("wrap_ready", 64'(fuReady), 64'(4'b0001));
        stepEdge();
        checkOutput("wrap_payload", 64'(cdbOut), 64'(expCdb(2'd0)));
        applyStimulus(4'b0010, 1'b0, 4'b0000);
        checkOutput("wrap_next_ready", 64'(fuReady), 64'(4'b0010));
        stepEdge();
        checkOutput("wrap_next_payload", 64'(cdbOut), 64'(expCdb(2'd1)));
        applyStimulus(4'b0011, 1'b0, 4'b0000);
        checkOutput("skip_ready", 64'(fuReady), 64'(4'b0001));
        stepEdge();

        // Flush collision: request blocked while flushing, granted once flush drops.
        applyStimulus(4'b0100, 1'b1, 4'b0000);
        checkOutput("flush_ready", 64'(fuReady), 64'(4'b0000));
        stepEdge();
        checkOutput("flush_valid", 64'(cdbOutValid), 64'(1'b0));
        checkOutput("flush_payload", 64'(cdbOut), 64'(0));
        applyStimulus(4'b0100, 1'b0, 4'b0000);
        checkOutput("post_flush_ready", 64'(fuReady), 64'(4'b0100));
        stepEdge();
        checkOutput("post_flush_valid", 64'(cdbOutValid), 64'(1'b1));
        checkOutput("post_flush_payload", 64'(cdbOut), 64'(expCdb(2'd2)));
        // Pointer is now 3 and must survive a flushed cycle.
        applyStimulus(4'b1111, 1'b1, 4'b0000);
        checkOutput("flush_all_ready", 64'(fuReady), 64'(4'b0000));
        stepEdge();
        checkOutput("flush_all_valid", 64'(cdbOutValid), 64'(1'b0));
        applyStimulus(4'b1111, 1'b0, 4'b0000);
        checkOutput("flush_ptr_held", 64'(fuReady), 64'(4'b1000));
        stepEdge();
        checkOutput("flush_ptr_payload", 64'(cdbOut), 64'(expCdb(2'd3)));
        applyStimulus(4'b0000, 1'b0, 4'b0000);
        stepEdge();
        checkOutput("rr_idle_valid", 64'(cdbOutValid), 64'(1'b0));

        // Fixed priority: unit 1 beats unit 3 every cycle; all valid always picks unit 0.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(4'b0000, 1'b0, 4'b1010);
            checkOutput($sformatf("fix_ready_%0d", k), 64'(fixReady), 64'(4'b0010));
            stepEdge();
            checkOutput($sformatf("fix_valid_%0d", k), 64'(fixCdbOutValid), 64'(1'b1));
            checkOutput($sformatf("fix_payload_%0d", k), 64'(fixCdbOut), 64'(expCdb(2'd1)));
        end
        for (int k = 0; k < 2; k++) begin
            applyStimulus(4'b0000, 1'b0, 4'b1111);
            checkOutput($sformatf("fix_all_ready_%0d", k), 64'(fixReady), 64'(4'b0001));
            stepEdge();
        end
        applyStimulus(4'b0000, 1'b0, 4'b0000);
        stepEdge();
        checkOutput("fix_idle_valid", 64'(fixCdbOutValid), 64'(1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
        $finish;
    end

endmodule
